// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle for the data memory arbiter.
//   CPU side : cpu_rd, cpu_wr, cpu_addr, cpu_wdata -> ; <- cpu_rdata, cpu_stall
//   Port B   : b_req, b_we, b_addr, b_wdata -> ; <- b_ack, b_rdata, b_err
//   Memory   : <- mem_rd, mem_wr, mem_addr, mem_wdata ; mem_rdata ->
//   slave modport = arbiter view, master modport = surrounding system view.
interface dmem_arbiter_if;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_ack;
   logic [31:0] b_rdata;
   logic        b_err;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      output cpu_rdata, cpu_stall, b_ack, b_rdata, b_err, mem_rd, mem_wr, mem_addr, mem_wdata
   );
   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      input  cpu_rdata, cpu_stall, b_ack, b_rdata, b_err, mem_rd, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU MEM stage
// (priority) and a secondary req/ack master B with a bounded starvation wait.
//   clk   : clock
//   reset : asynchronous active-low reset
//   arb_if: dmem_arbiter_if.slave bundle (CPU, port B and memory signals)
// Optional: define DMEM_ARB_RANGE_CHECK_EN to reject B accesses beyond RAM_SIZE
// words (memory strobes suppressed, b_err=1 and b_rdata=0 at the ack).
module dmem_arbiter #(
   parameter int RAM_SIZE     = 4096,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input logic            clk,
   input logic            reset,
   dmem_arbiter_if.slave  arb_if
);
   typedef enum logic [1:0] {S_CPU, S_B, S_ACK} state_t;
`ifdef DMEM_ARB_RANGE_CHECK_EN
   localparam logic RANGE_CHK = 1'b1;
`else
   localparam logic RANGE_CHK = 1'b0;
`endif
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic [31:0]       brdata_q, brdata_d;
   logic              err_q, err_d;
   logic              ack_q;
   logic              cpu_busy, grant, in_b, oor;
   assign cpu_busy = arb_if.cpu_rd | arb_if.cpu_wr;
   assign in_b     = state_q == S_B;
   // B may go when the CPU leaves the memory free, or once it has waited long enough
   assign grant    = arb_if.b_req & (~cpu_busy | (wait_q == CNT_W'(STARVE_LIMIT)));
   assign oor      = RANGE_CHK & ({2'b00, arb_if.b_addr[31:2]} >= 32'(RAM_SIZE));
   assign arb_if.mem_addr  = in_b ? arb_if.b_addr : arb_if.cpu_addr;
   assign arb_if.mem_wdata = in_b ? arb_if.b_wdata : arb_if.cpu_wdata;
   assign arb_if.mem_rd    = in_b ? (~arb_if.b_we & ~oor) : arb_if.cpu_rd;
   assign arb_if.mem_wr    = in_b ? (arb_if.b_we & ~oor) : arb_if.cpu_wr;
   assign arb_if.cpu_rdata = in_b ? 32'h0 : arb_if.mem_rdata;
   assign arb_if.cpu_stall = in_b & cpu_busy;
   assign arb_if.b_ack     = ack_q;
   assign arb_if.b_rdata   = brdata_q;
   assign arb_if.b_err     = err_q;
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      brdata_d = brdata_q;
      err_d    = err_q;
      case (state_q)
         S_CPU: begin
            state_d = grant ? S_B : S_CPU;
            wait_d  = (grant | ~arb_if.b_req) ? '0 :
                      (cpu_busy & (wait_q != '1)) ? wait_q + CNT_W'(1) : wait_q;
         end
         S_B: begin
            state_d  = S_ACK;
            brdata_d = oor ? 32'h0 : (arb_if.b_we ? brdata_q : arb_if.mem_rdata);
            err_d    = oor;
         end
         default: state_d = S_CPU;
      endcase
      if (!arb_if.b_req) wait_d = '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_CPU;
         wait_q   <= '0;
         ack_q    <= 1'b0;
         brdata_q <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         ack_q    <= in_b;
         brdata_q <= brdata_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus multi-cycle sequences for dmem_arbiter.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   logic clk, reset;
   dmem_arbiter_if arb_if ();
   dmem_arbiter #(.RAM_SIZE(4096), .STARVE_LIMIT(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .arb_if(arb_if)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   logic [31:0] mem [64];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_val;
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (arb_if.mem_wr) mem[arb_if.mem_addr[7:2]] <= arb_if.mem_wdata;
   end
   assign arb_if.mem_rdata = mem[arb_if.mem_addr[7:2]];
   int ncmp = 0;
   int nbad = 0;
   task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic drv(input logic crd, input logic cwr, input logic [31:0] ca, input logic [31:0] cwd,
                      input logic breq, input logic bwe, input logic [31:0] ba, input logic [31:0] bwd);
      arb_if.cpu_rd = crd; arb_if.cpu_wr = cwr; arb_if.cpu_addr = ca; arb_if.cpu_wdata = cwd;
      arb_if.b_req = breq; arb_if.b_we = bwe; arb_if.b_addr = ba; arb_if.b_wdata = bwd;
   endtask
   task automatic poke(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
   endtask
   task automatic idle();
      @(negedge clk);
      drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
   endtask
   // B transfer with the CPU idle: grant, S_B, S_ACK on three consecutive cycles
   task automatic b_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output logic sb_wr, output logic sb_rd,
                         output logic ack, output logic err, output logic [31:0] brd);
      @(negedge clk); drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, addr, wd); #1;
      @(negedge clk); #1; sb_wr = arb_if.mem_wr; sb_rd = arb_if.mem_rd;
      @(negedge clk); #1; ack = arb_if.b_ack; err = arb_if.b_err; brd = arb_if.b_rdata;
      idle();
   endtask
   typedef struct {
      logic crd, cwr; logic [31:0] ca, cwd;
      logic breq, bwe; logic [31:0] ba, bwd;
      logic mrd, mwr; logic [31:0] ma, mwd;
      logic st; logic [31:0] crdata; logic ack; logic [31:0] brd;
   } vec_t;
   vec_t tv [14];
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      int g, a, nst;
      logic [65:0] gbus;
      logic sw, sr, ak, er;
      logic [31:0] rd;
      tv[0]  = '{1'b1,1'b0,32'h10,32'h0,  1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h10,32'h0,  1'b0,32'hDEADBEEF,1'b0,32'h0};
      tv[1]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b0,32'h0};
      tv[2]  = '{1'b1,1'b0,32'h8,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,32'h10,32'h0,  1'b1,32'h0,1'b0,32'h0};
      tv[3]  = '{1'b1,1'b0,32'h8,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,32'h8,32'h0,   1'b0,32'h22222222,1'b1,32'hDEADBEEF};
      tv[4]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[5]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,32'h10,32'h0,  1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[6]  = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b1,32'hDEADBEEF};
      tv[7]  = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[8]  = '{1'b0,1'b1,32'h30,32'hA5, 1'b0,1'b0,32'h0,32'h0,  1'b0,1'b1,32'h30,32'hA5, 1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[9]  = '{1'b1,1'b0,32'h30,32'h0,  1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h30,32'h0,  1'b0,32'hA5,1'b0,32'hDEADBEEF};
      tv[10] = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b1,32'h2C,32'h77,1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[11] = '{1'b0,1'b0,32'h0,32'h0,   1'b1,1'b1,32'h2C,32'h77,1'b0,1'b1,32'h2C,32'h77, 1'b0,32'h0,1'b0,32'hDEADBEEF};
      tv[12] = '{1'b0,1'b0,32'h0,32'h0,   1'b0,1'b1,32'h2C,32'h77,1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,1'b1,32'hDEADBEEF};
      tv[13] = '{1'b1,1'b0,32'h2C,32'h0,  1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h2C,32'h0,  1'b0,32'h77,1'b0,32'hDEADBEEF};
      reset = 1'b0;
      pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 64; i++) poke(6'(i), 32'h0);
      poke(6'd2, 32'h22222222);
      poke(6'd4, 32'hDEADBEEF);
      @(negedge clk); pl_en = 1'b0; #1;
      chk("reset_out", {arb_if.b_ack, arb_if.b_err, arb_if.b_rdata, arb_if.cpu_stall}, {1'b0, 1'b0, 32'h0, 1'b0});
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drv(tv[i].crd, tv[i].cwr, tv[i].ca, tv[i].cwd, tv[i].breq, tv[i].bwe, tv[i].ba, tv[i].bwd);
         #1;
         chk($sformatf("vec%0d", i),
             {arb_if.mem_rd, arb_if.mem_wr, arb_if.mem_addr, arb_if.mem_wdata, arb_if.cpu_stall,
              arb_if.cpu_rdata, arb_if.b_ack, arb_if.b_rdata},
             {tv[i].mrd, tv[i].mwr, tv[i].ma, tv[i].mwd, tv[i].st, tv[i].crdata, tv[i].ack, tv[i].brd});
      end
      // starvation: CPU stores every cycle while B writes
      idle();
      g = -1; a = -1; nst = 0; gbus = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); drv(1'b0, 1'b1, 32'h20, 32'h11, 1'b1, 1'b1, 32'h24, 32'h55); #1;
         if (arb_if.cpu_stall) begin
            nst++;
            if (g < 0) begin g = k; gbus = {arb_if.mem_wr, arb_if.mem_rd, arb_if.mem_addr, arb_if.mem_wdata}; end
         end
         if (arb_if.b_ack && a < 0) a = k;
         if (a >= 0) break;
      end
      idle();
      chk("starve_grant_cycle", 132'(g), 132'(9));
      chk("starve_ack_cycle", 132'(a), 132'(10));
      chk("starve_stall_count", 132'(nst), 132'(1));
      chk("starve_grant_bus", 132'(gbus), 132'({1'b1, 1'b0, 32'h24, 32'h55}));
      chk("starve_mem9", 132'(mem[9]), 132'(32'h55));
      chk("starve_mem8", 132'(mem[8]), 132'(32'h11));
      // short request while CPU busy, then dropped: no grant, counter cleared
      idle();
      nst = 0; a = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); drv(1'b1, 1'b0, 32'h0, 32'h0, k < 3, 1'b0, 32'h24, 32'h0); #1;
         nst += int'(arb_if.cpu_stall); a += int'(arb_if.b_ack);
      end
      chk("drop_no_grant", 132'({nst, a}), 132'(64'h0));
      g = -1; a = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0); #1;
         if (arb_if.cpu_stall && g < 0) g = k;
         if (arb_if.b_ack && a < 0) begin a = k; rd = arb_if.b_rdata; end
         if (a >= 0) break;
      end
      idle();
      chk("drop_regrant_cycle", 132'(g), 132'(9));
      chk("drop_read_ack", 132'({a, rd}), 132'({32'd10, 32'h55}));
      // reset while B owns the memory
      idle();
      @(negedge clk); drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3C, 32'h99); #1;
      @(negedge clk); #1;
      chk("rst_sb_wr", 132'({arb_if.mem_wr, arb_if.mem_addr}), 132'({1'b1, 32'h3C}));
      reset = 1'b0; #1;
      chk("rst_async_out", 132'({arb_if.mem_wr, arb_if.b_ack, arb_if.b_rdata}), 132'(34'h0));
      drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk); #1;
      chk("rst_held_ack", 132'(arb_if.b_ack), 132'(1'b0));
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst_after", 132'({arb_if.b_ack, arb_if.b_rdata, mem[15]}), 132'(65'h0));
      // range check boundary
      b_xfer(1'b0, 32'h24, 32'h0, sw, sr, ak, er, rd);
      chk("pre_range_read", 132'({sr, ak, er, rd}), 132'({1'b1, 1'b1, 1'b0, 32'h55}));
      b_xfer(1'b1, 32'h4000, 32'h66, sw, sr, ak, er, rd);
      chk("range_wr_strobe", 132'({sw, sr}), 132'({!RC, 1'b0}));
      chk("range_ack", 132'({ak, er, rd}), 132'({1'b1, RC, RC ? 32'h0 : 32'h55}));
      b_xfer(1'b1, 32'h3FFC, 32'h44, sw, sr, ak, er, rd);
      chk("range_last_word", 132'({sw, ak, er}), 132'(3'b110));
      b_xfer(1'b0, 32'h10, 32'h0, sw, sr, ak, er, rd);
      chk("range_err_clear", 132'({sr, ak, er, rd}), 132'({1'b1, 1'b1, 1'b0, 32'hDEADBEEF}));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
